alarm_clock_core: RTL and testbench



---
 rtl/clock_pkg.sv | 14 +
 rtl/alarm_channel.sv | 112 +++++++++++
 rtl/alarm_clock_core.sv | 113 +++++++++++
 tb/tb_alarm_clock_core.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared seconds-of-day constants and width helper for the clock and output formatter
package clock_pkg;

    localparam int DAY_SECONDS     = 86400;
    localparam int SEC_PER_MIN     = 60;
    localparam int SEC_PER_HOUR    = 3600;
    localparam int SEC_PER_HALFDAY = 43200;

    // Bits needed to index 0..n-1; never narrower than one bit.
    function automatic int cw_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// rtl/alarm_channel.sv - one alarm channel: setpoint, match, ringing flag, snooze counter under ALARM_SNOOZE_EN
module alarm_channel
    import clock_pkg::*;
#(
    parameter int CW             = 17,
    parameter int SNOOZE_SECONDS = 300
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic          wr,
    input  logic [CW-1:0] wr_time,
    input  logic          en,
    input  logic          advance,
    input  logic [CW-1:0] next_time,
    input  logic          snooze,
    output logic          ringing
);

    logic [CW-1:0] setpoint_q;
    logic [CW-1:0] setpoint_d;
    logic          ring_q;
    logic          ring_d;
    logic          match;

    // Setpoint only changes on a write; the old value is still used for this edge's match.
    always_comb begin
        setpoint_d = setpoint_q;
        if (wr) begin
            setpoint_d = wr_time;
        end
    end

    // Only an advancing timestamp can match; loaded times never ring.
    assign match = en && advance && (next_time == setpoint_q);

`ifdef ALARM_SNOOZE_EN
    localparam int SW = cw_of(SNOOZE_SECONDS + 1);

    logic [SW-1:0] snz_cnt_q;
    logic [SW-1:0] snz_cnt_d;
    logic          snz_act_q;
    logic          snz_act_d;

    // Priority: disable clears everything, a fresh match beats snooze, then snooze countdown.
    always_comb begin
        ring_d    = ring_q;
        snz_cnt_d = snz_cnt_q;
        snz_act_d = snz_act_q;
        if (!en) begin
            ring_d    = 1'b0;
            snz_act_d = 1'b0;
            snz_cnt_d = '0;
        end else if (match) begin
            ring_d    = 1'b1;
            snz_act_d = 1'b0;
            snz_cnt_d = '0;
        end else if (snooze && ring_q) begin
            ring_d    = 1'b0;
            snz_act_d = 1'b1;
            snz_cnt_d = SW'(SNOOZE_SECONDS);
        end else if (snz_act_q && advance) begin
            // advance is already low while set_flag is high, which freezes the countdown.
            if (snz_cnt_q <= SW'(1)) begin
                ring_d    = 1'b1;
                snz_act_d = 1'b0;
                snz_cnt_d = '0;
            end else begin
                snz_cnt_d = snz_cnt_q - SW'(1);
            end
        end
    end

    // Snooze counter state; idle after reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            snz_cnt_q <= '0;
            snz_act_q <= 1'b0;
        end else begin
            snz_cnt_q <= snz_cnt_d;
            snz_act_q <= snz_act_d;
        end
    end
`else
    logic unused_snooze;

    // Without snooze the flag is simply set by a match and cleared by disable.
    always_comb begin
        ring_d = ring_q;
        if (!en) begin
            ring_d = 1'b0;
        end else if (match) begin
            ring_d = 1'b1;
        end
    end

    assign unused_snooze = snooze ^ (SNOOZE_SECONDS > 0);
`endif

    // Setpoint and ringing flag registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            setpoint_q <= '0;
            ring_q     <= 1'b0;
        end else begin
            setpoint_q <= setpoint_d;
            ring_q     <= ring_d;
        end
    end

    assign ringing = ring_q;

endmodule

// File: rtl/alarm_clock_core.sv
// rtl/alarm_clock_core.sv - seconds-of-day clock with NUM_ALARMS channels; snooze under ALARM_SNOOZE_EN
module alarm_clock_core #(
    parameter int  TICKS_PER_SEC  = 2,
    parameter int  DAY_SECONDS    = clock_pkg::DAY_SECONDS,
    parameter int  NUM_ALARMS     = 4,
    parameter int  SNOOZE_SECONDS = 300,
    localparam int CW             = clock_pkg::cw_of(DAY_SECONDS),
    localparam int AW             = clock_pkg::cw_of(NUM_ALARMS)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  set_flag,
    input  logic [CW-1:0]         set_time,
    input  logic                  alarm_wr,
    input  logic [AW-1:0]         alarm_sel,
    input  logic [CW-1:0]         alarm_wr_time,
    input  logic [NUM_ALARMS-1:0] alarm_en,
    input  logic [NUM_ALARMS-1:0] snooze,
    output logic [CW-1:0]         counter_state,
    output logic                  sec_tick,
    output logic [NUM_ALARMS-1:0] alarm_state,
    output logic                  alarm_any
);

    localparam int            PW         = clock_pkg::cw_of(TICKS_PER_SEC);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
    localparam logic [CW-1:0] TIME_LAST  = CW'(DAY_SECONDS - 1);
    localparam logic [CW:0]   DAY_LIM    = (CW + 1)'(DAY_SECONDS);

    logic [PW-1:0]         presc_q;
    logic [PW-1:0]         presc_d;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_d;
    logic                  tick_q;
    logic                  tick_d;
    logic                  alarm_any_q;
    logic                  alarm_any_d;
    logic                  advance;
    logic [CW-1:0]         next_time;
    logic [CW-1:0]         load_time;
    logic [NUM_ALARMS-1:0] ring;

    assign advance   = !set_flag && (presc_q == PRESC_LAST);
    assign next_time = (count_q == TIME_LAST) ? '0 : count_q + CW'(1);
    assign load_time = ({1'b0, set_time} >= DAY_LIM) ? '0 : set_time;

    // Prescaler wraps at terminal count and is held at zero while setting.
    always_comb begin
        presc_d = presc_q + PW'(1);
        if (set_flag || (presc_q == PRESC_LAST)) begin
            presc_d = '0;
        end
    end

    // Timestamp: load while setting, otherwise advance once per prescaler wrap.
    always_comb begin
        count_d = count_q;
        tick_d  = 1'b0;
        if (set_flag) begin
            count_d = load_time;
        end else if (advance) begin
            count_d = next_time;
            tick_d  = 1'b1;
        end
    end

    // Summary flag follows the channel flags one edge later.
    always_comb begin
        alarm_any_d = |ring;
    end

    // Prescaler, timestamp and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            presc_q     <= '0;
            count_q     <= '0;
            tick_q      <= 1'b0;
            alarm_any_q <= 1'b0;
        end else begin
            presc_q     <= presc_d;
            count_q     <= count_d;
            tick_q      <= tick_d;
            alarm_any_q <= alarm_any_d;
        end
    end

    // One channel per alarm; a select beyond NUM_ALARMS-1 matches no channel.
    for (genvar gi = 0; gi < NUM_ALARMS; gi++) begin : g_ch
        logic wr_hit;
        assign wr_hit = alarm_wr && (alarm_sel == AW'(gi));

        alarm_channel #(
            .CW             (CW),
            .SNOOZE_SECONDS (SNOOZE_SECONDS)
        ) u_ch (
            .clock     (clock),
            .reset_n   (reset_n),
            .wr        (wr_hit),
            .wr_time   (alarm_wr_time),
            .en        (alarm_en[gi]),
            .advance   (advance),
            .next_time (next_time),
            .snooze    (snooze[gi]),
            .ringing   (ring[gi])
        );
    end

    assign counter_state = count_q;
    assign sec_tick      = tick_q;
    assign alarm_state   = ring;
    assign alarm_any     = alarm_any_q;

endmodule

// File: tb/tb_alarm_clock_core.sv
// tb/tb_alarm_clock_core.sv - scoreboard bench for alarm_clock_core (five channels so a select of 5 is out of range)
module tb_alarm_clock_core;

    localparam int CW = 17;
    localparam int NA = 5;
    localparam int AW = 3;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          set_flag;
    logic [CW-1:0] set_time;
    logic          alarm_wr;
    logic [AW-1:0] alarm_sel;
    logic [CW-1:0] alarm_wr_time;
    logic [NA-1:0] alarm_en;
    logic [NA-1:0] snooze;
    logic [CW-1:0] counter_state;
    logic          sec_tick;
    logic [NA-1:0] alarm_state;
    logic          alarm_any;

    alarm_clock_core #(
        .TICKS_PER_SEC  (2),
        .DAY_SECONDS    (86400),
        .NUM_ALARMS     (NA),
        .SNOOZE_SECONDS (3)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .set_flag      (set_flag),
        .set_time      (set_time),
        .alarm_wr      (alarm_wr),
        .alarm_sel     (alarm_sel),
        .alarm_wr_time (alarm_wr_time),
        .alarm_en      (alarm_en),
        .snooze        (snooze),
        .counter_state (counter_state),
        .sec_tick      (sec_tick),
        .alarm_state   (alarm_state),
        .alarm_any     (alarm_any)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Expected output snapshot; a field of -1 is not checked.
    typedef struct {
        int    at;
        string nm;
        int    cnt;
        int    alm;
        int    tick;
        int    any;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic push_exp(input string nm, input int k, input int cnt, input int alm,
                            input int tick, input int any);
        exp_t e;
        e.at   = cyc + k;
        e.nm   = nm;
        e.cnt  = cnt;
        e.alm  = alm;
        e.tick = tick;
        e.any  = any;
        exp_q.push_back(e);
    endtask

    task automatic cmp(input string nm, input string fld, input int act, input int req);
        if (req >= 0) begin
            n_chk++;
            if (act != req) begin
                n_fail++;
                $display("FAIL %s.%s at cycle %0d: got %0d, expected %0d", nm, fld, cyc, act, req);
            end
        end
    endtask

    // Monitor: on each falling edge, compare every expectation due this cycle.
    always @(negedge clock) begin
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].at <= cyc) begin
                if (exp_q[i].at < cyc) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL %s: due at cycle %0d but not sampled (now %0d)", exp_q[i].nm, exp_q[i].at, cyc);
                end else begin
                    cmp(exp_q[i].nm, "counter_state", int'(counter_state), exp_q[i].cnt);
                    cmp(exp_q[i].nm, "alarm_state", int'(alarm_state), exp_q[i].alm);
                    cmp(exp_q[i].nm, "sec_tick", int'(sec_tick), exp_q[i].tick);
                    cmp(exp_q[i].nm, "alarm_any", int'(alarm_any), exp_q[i].any);
                end
                exp_q.delete(i);
            end
        end
    end

    initial begin
        reset_n       = 1'b0;
        set_flag      = 1'b0;
        set_time      = '0;
        alarm_wr      = 1'b0;
        alarm_sel     = '0;
        alarm_wr_time = '0;
        alarm_en      = '0;
        snooze        = '0;

        // Reset state and free run from reset.
        step(2);
        push_exp("reset", 0, 0, 0, 0, 0);
        step(1);
        reset_n = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            push_exp("run", k, k / 2, 0, ((k % 2) == 0) ? 1 : 0, 0);
        end
        step(12);
        reset_n = 1'b0;
        push_exp("async_reset", 0, 0, 0, 0, 0);
        step(2);
        reset_n = 1'b1;

        // Set near midnight and wrap.
        set_flag = 1'b1;
        set_time = 17'd86398;
        step(1);
        set_flag = 1'b0;
        push_exp("set_load", 0, 86398, -1, 0, -1);
        push_exp("set_hold_pre", 1, 86398, -1, 0, -1);
        push_exp("pre_wrap", 2, 86399, -1, 1, -1);
        push_exp("wrap", 4, 0, -1, 1, -1);
        step(4);

        // Held set: constant value and no ticks.
        set_flag = 1'b1;
        set_time = 17'd34953;
        for (int k = 1; k <= 10; k++) begin
            push_exp("set_hold", k, 34953, -1, 0, -1);
        end
        step(10);
        set_time = 17'd100000;
        push_exp("set_oob", 1, 0, -1, 0, -1);
        step(1);

        // Channel 0 rings on the advance to its setpoint.
        set_time      = 17'd34953;
        alarm_wr      = 1'b1;
        alarm_sel     = 3'd0;
        alarm_wr_time = 17'd34961;
        alarm_en      = 5'b00001;
        step(1);
        alarm_wr = 1'b0;
        set_flag = 1'b0;
        push_exp("ch0_before", 14, 34960, 0, 1, 0);
        push_exp("ch0_ring", 16, 34961, 1, 1, 0);
        push_exp("ch0_any", 17, 34961, 1, 0, 1);
        step(17);
        alarm_en = 5'b00000;
        push_exp("en_clear", 1, -1, 0, -1, -1);
        push_exp("en_clear_any", 2, -1, 0, -1, 0);
        step(2);
        alarm_en = 5'b00001;
        set_flag = 1'b1;
        set_time = 17'd34960;
        step(1);
        set_flag = 1'b0;
        push_exp("retain_pre", 1, 34960, 0, 0, -1);
        push_exp("retain_ring", 2, 34961, 1, 1, -1);
        step(2);

        // Loading exactly the alarm time does not ring; one second before does.
        alarm_en      = 5'b00000;
        set_flag      = 1'b1;
        set_time      = 17'd50925;
        alarm_wr      = 1'b1;
        alarm_sel     = 3'd0;
        alarm_wr_time = 17'd50925;
        step(1);
        alarm_wr = 1'b0;
        alarm_en = 5'b00001;
        set_flag = 1'b0;
        push_exp("eq_load", 0, 50925, 0, -1, -1);
        push_exp("eq_no_ring", 2, 50926, 0, 1, -1);
        push_exp("eq_no_ring2", 4, 50927, 0, 1, -1);
        step(4);
        set_flag = 1'b1;
        set_time = 17'd50924;
        step(1);
        set_flag = 1'b0;
        push_exp("m1_pre", 1, 50924, 0, 0, -1);
        push_exp("m1_ring", 2, 50925, 1, 1, -1);
        step(3);

        // Two channels on the same setpoint; select 5 is out of range.
        alarm_en      = 5'b00000;
        set_flag      = 1'b1;
        set_time      = 17'd99;
        alarm_wr      = 1'b1;
        alarm_sel     = 3'd1;
        alarm_wr_time = 17'd100;
        step(1);
        alarm_sel = 3'd2;
        step(1);
        alarm_sel     = 3'd5;
        alarm_wr_time = 17'd200;
        step(1);
        alarm_wr = 1'b0;
        alarm_en = 5'b00110;
        step(1);
        set_flag = 1'b0;
        push_exp("dual_pre", 0, 99, 0, -1, 0);
        push_exp("dual_ring", 2, 100, 6, 1, 0);
        push_exp("dual_any", 3, 100, 6, 0, 1);
        step(3);

        // Snooze channel 1 while both ring.
        snooze = 5'b00010;
        step(1);
        snooze = 5'b00000;
`ifdef ALARM_SNOOZE_EN
        push_exp("snz_clear", 0, 101, 4, 1, 1);
        push_exp("snz_wait", 4, 103, 4, 1, 1);
        push_exp("snz_wait2", 5, 103, 4, 0, 1);
        push_exp("snz_reset", 6, 104, 6, 1, 1);
`else
        push_exp("snz_ignored", 0, 101, 6, 1, 1);
        push_exp("snz_ignored2", 6, 104, 6, 1, 1);
`endif
        step(8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
